s420_sched: RTL and testbench

S420_SCHED -- requirements
Module: s420_sched

---
 rtl/s420_sched.sv | 111 +++++++++++
 tb/tb_s420_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/s420_sched.sv
// s420_sched: round-robin job controller sharing one s420 counter/compare datapath.
module s420_sched #(
    parameter int N_REQ = 4,
    parameter int LIMIT = 65535
) (
    input  logic                CK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    REQ,
    input  logic [17*N_REQ-1:0] CFG,
    input  logic                Z,
    output logic [N_REQ-1:0]    GNT,
    output logic [N_REQ-1:0]    DONE,
    output logic                HIT,
    output logic [15:0]         STEPS,
    output logic                P_0,
    output logic [16:0]         C
);
    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} state_t;
    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d, win;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d, win_oh;
    logic             hit_q, hit_d, p0_q, p0_d, found;
    logic [15:0]      steps_q, steps_d, steps_inc;
    logic [16:0]      c_q, c_d, win_cfg;

    // Two passes over the requesters: first from ptr upward, then wrapping from 0.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_oh  = '0;
        win_cfg = '0;
        for (int j = 0; j < 2 * N_REQ; j++)
            if (!found && REQ[j % N_REQ] && (j >= N_REQ || j >= int'(ptr_q))) begin
                found                 = 1'b1;
                win                   = PW'(j % N_REQ);
                win_oh[j % N_REQ]     = 1'b1;
                win_cfg               = CFG[17*(j % N_REQ) +: 17];
            end
    end

    assign steps_inc = steps_q + 16'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        hit_d   = hit_q;
        steps_d = steps_q;
        p0_d    = 1'b0;
        c_d     = c_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = LOAD;
                gnt_d   = win_oh;
                c_d     = win_cfg;
                steps_d = '0;
                hit_d   = 1'b0;
                ptr_d   = (int'(win) == N_REQ - 1) ? '0 : win + PW'(1);
            end
            LOAD: begin
                state_d = RUN;
                p0_d    = 1'b1;
            end
            RUN: begin
                steps_d = steps_inc;
                if (Z || steps_inc == 16'(LIMIT)) begin
                    state_d = REPORT;
                    done_d  = gnt_q;
                    hit_d   = Z;
                end else begin
                    p0_d = 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            hit_q   <= 1'b0;
            steps_q <= '0;
            p0_q    <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            steps_q <= steps_d;
            p0_q    <= p0_d;
            c_q     <= c_d;
        end
    end

    assign GNT   = gnt_q;
    assign DONE  = done_q;
    assign HIT   = hit_q;
    assign STEPS = steps_q;
    assign P_0   = p0_q;
    assign C     = c_q;
endmodule

// File: tb/tb_s420_sched.sv
// tb_s420_sched: randomized job stimulus checked against a round-robin/step-count reference model.
module tb_s420_sched;
    localparam int N = 4;
    localparam int LIM = 8;
    logic        CK = 1'b0;
    logic        RST, Z, z_tb, use_stub;
    logic [3:0]  REQ, GNT, DONE;
    logic [67:0] CFG;
    logic        HIT, P_0;
    logic [15:0] STEPS;
    logic [16:0] C;
    int total = 0, bad = 0, cyc = 0, ptr_m = 0, last_g = 0;
    logic        prev_hit;
    logic [15:0] prev_steps;

    s420_sched #(.N_REQ(N), .LIMIT(LIM)) dut (
        .CK(CK), .RST(RST), .REQ(REQ), .CFG(CFG), .Z(Z),
        .GNT(GNT), .DONE(DONE), .HIT(HIT), .STEPS(STEPS), .P_0(P_0), .C(C)
    );

    // Integration stub mimics the datapath's C_0 & P_0 match term.
    assign Z = use_stub ? (C[0] & P_0) : z_tb;

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    function automatic int model_win(input logic [3:0] r);
        for (int k = 0; k < N; k++)
            if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return 0;
    endfunction

    function automatic logic [67:0] rnd_cfg();
        return {4'($urandom), $urandom, $urandom};
    endfunction

    task automatic do_job(input logic [3:0] req, input int zc, input bit scr,
                          input logic [67:0] cfg, output logic [3:0] g_obs, output int gap);
        logic [3:0]  ge;
        logic [16:0] ce;
        int win, pc, g_cyc, exp_steps;
        bit got, exp_hit, unstable;
        REQ = req;
        CFG = cfg;
        win = model_win(req);
        ge = 4'b0001 << win;
        ce = cfg[17*win +: 17];
        exp_hit = zc >= 1 && zc <= LIM;
        exp_steps = exp_hit ? zc : LIM;
        got = 0;
        g_obs = '0;
        gap = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge CK);
            if (GNT !== 4'b0) got = 1;
            else begin
                total++;
                if (DONE !== 4'b0 || P_0 !== 1'b0 || HIT !== prev_hit || STEPS !== prev_steps) begin
                    bad++;
                    $display("FAIL idle: done=%b p0=%b hit=%b steps=%0d, need 0/0/%b/%0d",
                             DONE, P_0, HIT, STEPS, prev_hit, prev_steps);
                end
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL grant_timeout: gnt=%b need %b", GNT, ge);
            return;
        end
        g_obs = GNT;
        g_cyc = cyc;
        gap = g_cyc - last_g;
        last_g = g_cyc;
        ptr_m = (win + 1) % N;
        if (GNT !== ge) begin bad++; $display("FAIL gnt: got %b need %b", GNT, ge); end
        total++;
        if (C !== ce) begin bad++; $display("FAIL c: got %h need %h", C, ce); end
        total++;
        if (STEPS !== 16'd0 || HIT !== 1'b0 || P_0 !== 1'b0)
            begin bad++; $display("FAIL load: steps=%0d hit=%b p0=%b need 0/0/0", STEPS, HIT, P_0); end
        if (scr) begin
            REQ = 4'($urandom);
            CFG = rnd_cfg();
        end
        z_tb = 1'($urandom);
        pc = 0;
        got = 0;
        unstable = 0;
        for (int i = 0; i < LIM + 5 && !got; i++) begin
            @(negedge CK);
            if (GNT !== ge || C !== ce) unstable = 1;
            if (DONE !== 4'b0) got = 1;
            else if (P_0 === 1'b1) begin
                pc++;
                z_tb = (pc == zc);
            end else z_tb = 1'($urandom);
        end
        z_tb = 1'($urandom);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL done_timeout: run cycles %0d need %0d", pc, exp_steps);
            return;
        end
        total++;
        if (unstable) begin bad++; $display("FAIL in_flight: gnt/c changed, need %b/%h", ge, ce); end
        total++;
        if (DONE !== ge) begin bad++; $display("FAIL done: got %b need %b", DONE, ge); end
        total++;
        if (HIT !== exp_hit || STEPS !== 16'(exp_steps))
            begin bad++; $display("FAIL result: hit=%b steps=%0d need %b/%0d", HIT, STEPS, exp_hit, exp_steps); end
        total++;
        if (pc != exp_steps || P_0 !== 1'b0)
            begin bad++; $display("FAIL p0_cycles: got %0d p0=%b need %0d p0=0", pc, P_0, exp_steps); end
        total++;
        if (cyc - g_cyc != exp_steps + 1)
            begin bad++; $display("FAIL latency: got %0d need %0d", cyc - g_cyc, exp_steps + 1); end
        prev_hit = exp_hit;
        prev_steps = 16'(exp_steps);
    endtask

    task automatic test_reset;
        @(negedge CK);
        RST = 1'b1;
        REQ = '0;
        z_tb = 1'b0;
        @(negedge CK);
        @(negedge CK);
        total++;
        if ({GNT, DONE, HIT, STEPS, P_0, C} !== '0)
            begin bad++; $display("FAIL reset: gnt=%b done=%b hit=%b steps=%0d p0=%b c=%h need all 0",
                                  GNT, DONE, HIT, STEPS, P_0, C); end
        RST = 1'b0;
        ptr_m = 0;
        prev_hit = 1'b0;
        prev_steps = '0;
        last_g = cyc;
    endtask

    task automatic test_single;
        logic [67:0] cfg;
        logic [3:0] g;
        int gap;
        cfg = rnd_cfg();
        cfg[33:17] = 17'h00001;
        do_job(4'b0010, 3, 0, cfg, g, gap);
        total++;
        if (g !== 4'b0010) begin bad++; $display("FAIL single_gnt: got %b need 0010", g); end
    endtask

    task automatic test_limits;
        logic [3:0] g;
        int gap;
        do_job(4'b0100, 0, 0, rnd_cfg(), g, gap);
        do_job(4'b1000, LIM, 0, rnd_cfg(), g, gap);
        do_job(4'b0001, LIM + 1, 0, rnd_cfg(), g, gap);
    endtask

    task automatic test_back_to_back;
        logic [3:0] g;
        int gap;
        test_reset();
        for (int j = 0; j < 5; j++) begin
            do_job(4'b1111, 1, 0, rnd_cfg(), g, gap);
            total++;
            if (g !== 4'b0001 << (j % N)) begin bad++; $display("FAIL rr_order: job %0d got %b", j, g); end
            if (j > 0) begin
                total++;
                if (gap != 4) begin bad++; $display("FAIL rr_period: got %0d need 4", gap); end
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] g, r;
        int gap;
        for (int j = 0; j < 25; j++) begin
            r = 4'($urandom);
            if (r == 4'b0) r = 4'b0100;
            do_job(r, $urandom_range(0, LIM + 2), 1, rnd_cfg(), g, gap);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] g;
        int pc, gap;
        bit seen;
        REQ = 4'b0100;
        CFG = rnd_cfg();
        z_tb = 1'b0;
        pc = 0;
        for (int i = 0; i < 8 && pc < 2; i++) begin
            @(negedge CK);
            if (P_0 === 1'b1) pc++;
        end
        total++;
        if (pc != 2) begin bad++; $display("FAIL mid_run: run cycles %0d need 2", pc); end
        RST = 1'b1;
        REQ = 4'b1000;
        @(negedge CK);
        total++;
        if ({GNT, DONE, HIT, STEPS, P_0, C} !== '0)
            begin bad++; $display("FAIL mid_reset: gnt=%b done=%b hit=%b steps=%0d p0=%b c=%h need all 0",
                                  GNT, DONE, HIT, STEPS, P_0, C); end
        RST = 1'b0;
        ptr_m = 0;
        prev_hit = 1'b0;
        prev_steps = '0;
        seen = 0;
        do_job(4'b1000, 2, 0, rnd_cfg(), g, gap);
        total++;
        if (g !== 4'b1000) begin bad++; $display("FAIL post_reset_gnt: got %b need 1000", g); end
        @(negedge CK);
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        ptr_m = 0;
        prev_hit = 1'b0;
        prev_steps = '0;
        do_job(4'b1001, 1, 0, rnd_cfg(), g, gap);
        total++;
        if (g !== 4'b0001) begin bad++; $display("FAIL post_reset_prio: got %b need 0001", g); end
    endtask

    task automatic test_integration;
        logic [67:0] cfg;
        logic [3:0] g;
        int gap;
        use_stub = 1'b1;
        cfg = rnd_cfg();
        cfg[16:0] = 17'h00001;
        do_job(4'b0001, 1, 0, cfg, g, gap);
        use_stub = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        use_stub = 1'b0;
        REQ = '0;
        CFG = '0;
        z_tb = 1'b0;
        test_reset();
        test_single();
        test_limits();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_integration();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
